// File: rtl/l1_trig_pkg.sv
// Shared types and helpers for the L1 trigger event builder.
package l1_trig_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WINDOW,
    EMIT,
    HOLDOFF
  } evb_state_t;

  // Marks the header word of an event; beam words carry 0 in bit 31.
  localparam logic HDR_FLAG = 1'b1;

  // Each beam word carries 31 beam bits below the flag bit.
  localparam int BEAM_BITS = 31;

  // Number of beam words needed to carry nbeams trigger bits.
  function automatic int nwords(input int nbeams);
    return (nbeams + BEAM_BITS - 1) / BEAM_BITS;
  endfunction

endpackage

// File: rtl/trig_word_fifo.sv
// First-word-fall-through FIFO of 32-bit trigger words with an occupancy count.
// The head word reads as zero while the FIFO is empty.
module trig_word_fifo #(
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [31:0]            wdata,
  input  logic                   pop,
  output logic [31:0]            rdata,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   used;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign valid   = (used != '0);
  assign full    = (used == (AW+1)'(DEPTH));
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign rdata   = valid ? mem[rd_ptr] : '0;
  assign count   = used;

  // Pointer and occupancy bookkeeping; reset and flush both empty the FIFO.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      used   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   used <= used + (AW+1)'(1);
        2'b01:   used <= used - (AW+1)'(1);
        default: used <= used;
      endcase
    end
  end

  // Storage array; a word written while a flush is pending is discarded.
  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/l1_trigger_event_builder.sv
// Collects masked beam triggers over a coincidence window, timestamps the event
// and streams it out as a header word followed by beam words over AXI4-Stream.
module l1_trigger_event_builder
  import l1_trig_pkg::*;
#(
  parameter int NBEAMS       = 48,
  parameter int WINDOW       = 4,
  parameter int HOLDOFF_BITS = 16,
  parameter int FIFO_DEPTH   = 64
) (
  input  logic                    ifclk,
  input  logic                    ifclk_rst_i,
  input  logic                    runrst_i,
  input  logic                    runstop_i,
  input  logic [NBEAMS-1:0]       trig_i,
  input  logic [NBEAMS-1:0]       beam_mask_i,
  input  logic [HOLDOFF_BITS-1:0] holdoff_i,
  output logic [31:0]             m_trig_tdata,
  output logic                    m_trig_tvalid,
  input  logic                    m_trig_tready,
  output logic                    running_o,
  output logic [31:0]             event_count_o,
  output logic [15:0]             drop_count_o
);

  localparam int NWORDS = nwords(NBEAMS);
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;
  localparam int WCW    = $clog2(WINDOW + 1);
  localparam int IW     = $clog2(NWORDS + 1);

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] NEED_C  = CW'(1 + NWORDS);

  evb_state_t              state;
  logic [31:0]             ts;
  logic [30:0]             ts_lat;
  logic [NBEAMS-1:0]       acc;
  logic [WCW-1:0]          win_cnt;
  logic [IW-1:0]           widx;
  logic [HOLDOFF_BITS-1:0] ho_cnt;
  logic                    running;
  logic [31:0]             event_count;
  logic [15:0]             drop_count;

  logic [NBEAMS-1:0]       masked;
  logic                    hit;
  logic                    has_space;
  logic [CW-1:0]           fifo_count;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic [31:0]             word;
  logic [31*NWORDS-1:0]    acc_pad;
  logic [30:0]             beam_sel;

  assign masked    = trig_i & ~beam_mask_i;
  assign hit       = |masked;
  assign has_space = (DEPTH_C - fifo_count) >= NEED_C;
  assign fifo_push = (state == EMIT);
  assign fifo_pop  = m_trig_tvalid && m_trig_tready && !ifclk_rst_i && !runrst_i;

  assign running_o     = running;
  assign event_count_o = event_count;
  assign drop_count_o  = drop_count;

  // Selects the word being emitted: header with timestamp, then 31-bit beam slices.
  always_comb begin
    acc_pad = '0;
    acc_pad[NBEAMS-1:0] = acc;
    beam_sel = '0;
    for (int k = 0; k < NWORDS; k++) begin
      if (widx == IW'(k + 1)) beam_sel = acc_pad[31*k +: 31];
    end
    word = (widx == '0) ? {HDR_FLAG, ts_lat} : {1'b0, beam_sel};
  end

  // Run control, timestamp, counters and the event FSM in one registered process.
  always_ff @(posedge ifclk) begin
    if (ifclk_rst_i || runrst_i) begin
      state       <= IDLE;
      ts          <= '0;
      ts_lat      <= '0;
      acc         <= '0;
      win_cnt     <= '0;
      widx        <= '0;
      ho_cnt      <= '0;
      event_count <= '0;
      drop_count  <= '0;
      running     <= ifclk_rst_i ? 1'b0 : !runstop_i;
    end else begin
      ts <= ts + 32'd1;
      if (runstop_i) running <= 1'b0;
      case (state)
        IDLE: begin
          if (running && hit) begin
            ts_lat  <= ts[30:0];
            acc     <= masked;
            win_cnt <= WCW'(1);
            widx    <= '0;
            if (WINDOW == 1) begin
              if (has_space) begin
                state <= EMIT;
              end else begin
                if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
                if (holdoff_i == '0) state <= IDLE;
                else begin
                  state  <= HOLDOFF;
                  ho_cnt <= holdoff_i;
                end
              end
            end else begin
              state <= l1_trig_pkg::WINDOW;
            end
          end
        end
        l1_trig_pkg::WINDOW: begin
          acc     <= acc | masked;
          win_cnt <= win_cnt + WCW'(1);
          if (win_cnt == WCW'(WINDOW - 1)) begin
            if (has_space) begin
              state <= EMIT;
            end else begin
              if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
              if (holdoff_i == '0) state <= IDLE;
              else begin
                state  <= HOLDOFF;
                ho_cnt <= holdoff_i;
              end
            end
          end
        end
        EMIT: begin
          widx <= widx + IW'(1);
          if (widx == IW'(NWORDS)) begin
            event_count <= event_count + 32'd1;
            if (holdoff_i == '0) state <= IDLE;
            else begin
              state  <= HOLDOFF;
              ho_cnt <= holdoff_i;
            end
          end
        end
        HOLDOFF: begin
          if (ho_cnt == HOLDOFF_BITS'(1)) state <= IDLE;
          else ho_cnt <= ho_cnt - HOLDOFF_BITS'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  trig_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (ifclk),
    .rst   (ifclk_rst_i),
    .flush (runrst_i),
    .push  (fifo_push),
    .wdata (word),
    .pop   (fifo_pop),
    .rdata (m_trig_tdata),
    .valid (m_trig_tvalid),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_l1_trigger_event_builder.sv
// Self-checking bench: a deadline-based event model predicts the output stream
// every cycle, and directed scenarios pin literal words and counter values.
module tb_l1_trigger_event_builder;

  localparam int NBEAMS = 48;
  localparam int WIN    = 4;
  localparam int HB     = 16;
  localparam int DEPTH  = 8;
  localparam int NW     = (NBEAMS + 30) / 31;

  logic              clk = 1'b0;
  logic              rst;
  logic              runrst;
  logic              runstop;
  logic [NBEAMS-1:0] trig;
  logic [NBEAMS-1:0] mask;
  logic [HB-1:0]     holdoff;
  logic [31:0]       tdata;
  logic              tvalid;
  logic              tready;
  logic              running;
  logic [31:0]       evt_cnt;
  logic [15:0]       drop_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] got [$];

  l1_trigger_event_builder #(
    .NBEAMS       (NBEAMS),
    .WINDOW       (WIN),
    .HOLDOFF_BITS (HB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .ifclk         (clk),
    .ifclk_rst_i   (rst),
    .runrst_i      (runrst),
    .runstop_i     (runstop),
    .trig_i        (trig),
    .beam_mask_i   (mask),
    .holdoff_i     (holdoff),
    .m_trig_tdata  (tdata),
    .m_trig_tvalid (tvalid),
    .m_trig_tready (tready),
    .running_o     (running),
    .event_count_o (evt_cnt),
    .drop_count_o  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    longint      at;
    logic [31:0] w;
    bit          last;
  } push_t;

  logic [31:0]       m_ts;
  bit                m_run;
  logic [31:0]       m_evt;
  int                m_drop;
  logic [31:0]       m_fifo [$];
  push_t             m_pend [$];
  bit                m_open;
  longint            m_close_at;
  longint            m_free_at;
  logic [NBEAMS-1:0] m_acc;
  logic [31:0]       m_hdr;
  longint            cyc = 0;
  bit                model_live = 0;

  // Advance the model by one cycle using the inputs that were present during it.
  always @(posedge clk) begin
    logic [NBEAMS-1:0] mt;
    logic [31*NW-1:0]  pad;
    int                occ;
    bit                pop;
    push_t             p;
    mt = trig & ~mask;
    cyc++;
    model_live = 1;
    if (rst || runrst) begin
      m_ts = 0;
      m_fifo.delete();
      m_pend.delete();
      m_open = 0;
      m_free_at = 0;
      m_evt = 0;
      m_drop = 0;
      m_run = rst ? 1'b0 : !runstop;
    end else begin
      occ = m_fifo.size();
      pop = (occ != 0) && tready;
      if (!m_open && cyc >= m_free_at && m_run && mt != '0) begin
        m_open = 1;
        m_acc = mt;
        m_hdr = {1'b1, m_ts[30:0]};
        m_close_at = cyc + WIN - 1;
      end else if (m_open) begin
        m_acc = m_acc | mt;
      end
      if (m_open && cyc == m_close_at) begin
        m_open = 0;
        if (DEPTH - occ >= 1 + NW) begin
          pad = '0;
          pad[NBEAMS-1:0] = m_acc;
          for (int k = 0; k <= NW; k++) begin
            p.at = cyc + 1 + k;
            p.last = (k == NW);
            if (k == 0) p.w = m_hdr;
            else p.w = {1'b0, pad[31*(k-1) +: 31]};
            m_pend.push_back(p);
          end
          m_free_at = cyc + NW + 2 + longint'(holdoff);
        end else begin
          if (m_drop < 16'hFFFF) m_drop++;
          m_free_at = cyc + 1 + longint'(holdoff);
        end
      end
      if (pop) void'(m_fifo.pop_front());
      if (m_pend.size() != 0 && m_pend[0].at == cyc) begin
        m_fifo.push_back(m_pend[0].w);
        if (m_pend[0].last) m_evt = m_evt + 1;
        void'(m_pend.pop_front());
      end
      m_ts = m_ts + 1;
      if (runstop) m_run = 0;
    end
  end

  // Compare every DUT output against the model once per cycle, away from the edge.
  always @(negedge clk) begin
    if (model_live) begin
      check_output("tvalid", 32'(tvalid), 32'(m_fifo.size() != 0));
      check_output("tdata", tdata, (m_fifo.size() != 0) ? m_fifo[0] : 32'h0);
      check_output("running", 32'(running), 32'(m_run));
      check_output("event_count", evt_cnt, m_evt);
      check_output("drop_count", 32'(drop_cnt), 32'(m_drop));
    end
  end

  // Record words accepted by the downstream for the directed literal checks.
  always @(negedge clk) begin
    if (!rst && !runrst && tvalid && tready) got.push_back(tdata);
  end

  // Keep the run bounded even if the stimulus sequence stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic apply_stimulus_run_reset(input bit with_stop);
    got.delete();
    runrst = 1'b1;
    runstop = with_stop;
    step(1);
    runrst = 1'b0;
    runstop = 1'b0;
  endtask

  task automatic pulse(input int beam);
    trig = '0;
    trig[beam] = 1'b1;
    step(1);
    trig = '0;
  endtask

  initial begin
    rst = 1'b1; runrst = 1'b0; runstop = 1'b0;
    trig = '0; mask = '0; holdoff = '0; tready = 1'b1;
    step(3);
    check_output("rst_tvalid", 32'(tvalid), 32'h0);
    check_output("rst_tdata", tdata, 32'h0);
    check_output("rst_running", 32'(running), 32'h0);
    check_output("rst_events", evt_cnt, 32'h0);
    rst = 1'b0;
    step(2);
    check_output("idle_running", 32'(running), 32'h0);

    // Single beam 5 hit at ts=100.
    apply_stimulus_run_reset(1'b0);
    check_output("run_running", 32'(running), 32'h1);
    step(100);
    pulse(5);
    step(12);
    check_output("s1_nwords", got.size(), 32'd3);
    check_output("s1_w0", got.size() > 0 ? got[0] : 32'hDEAD, 32'h80000064);
    check_output("s1_w1", got.size() > 1 ? got[1] : 32'hDEAD, 32'h00000020);
    check_output("s1_w2", got.size() > 2 ? got[2] : 32'hDEAD, 32'h00000000);
    check_output("s1_events", evt_cnt, 32'd1);

    // Bit 3 at ts=10 and bit 40 at ts=13 merge into one event.
    apply_stimulus_run_reset(1'b0);
    step(10);
    pulse(3);
    step(2);
    pulse(40);
    step(12);
    check_output("s2_nwords", got.size(), 32'd3);
    check_output("s2_w0", got.size() > 0 ? got[0] : 32'hDEAD, 32'h8000000A);
    check_output("s2_w1", got.size() > 1 ? got[1] : 32'hDEAD, 32'h00000008);
    check_output("s2_w2", got.size() > 2 ? got[2] : 32'hDEAD, 32'h00000200);

    // Bit 40 one cycle after the window closes is ignored.
    apply_stimulus_run_reset(1'b0);
    step(10);
    pulse(3);
    step(3);
    pulse(40);
    step(12);
    check_output("s2b_nwords", got.size(), 32'd3);
    check_output("s2b_w2", got.size() > 2 ? got[2] : 32'hDEAD, 32'h00000000);
    check_output("s2b_events", evt_cnt, 32'd1);

    // Backpressure: four events into an 8-word FIFO, two fit and two drop.
    tready = 1'b0;
    apply_stimulus_run_reset(1'b0);
    step(2);
    pulse(0);
    step(9);
    pulse(0);
    step(9);
    pulse(0);
    step(9);
    pulse(0);
    step(6);
    check_output("s3_events", evt_cnt, 32'd2);
    check_output("s3_drops", 32'(drop_cnt), 32'd2);
    check_output("s3_tvalid", 32'(tvalid), 32'h1);
    check_output("s3_head", tdata, 32'h80000002);
    step(3);
    check_output("s3_head_stable", tdata, 32'h80000002);
    tready = 1'b1;
    step(20);
    check_output("s3_drained", got.size(), 32'd6);
    check_output("s3_w1", got.size() > 1 ? got[1] : 32'hDEAD, 32'h00000001);
    check_output("s3_w3", got.size() > 3 ? got[3] : 32'hDEAD, 32'h8000000C);
    check_output("s3_empty", 32'(tvalid), 32'h0);

    // Masked beam never opens a window.
    apply_stimulus_run_reset(1'b0);
    mask[7] = 1'b1;
    step(1);
    pulse(7);
    step(10);
    check_output("s4_mask_events", evt_cnt, 32'd0);
    check_output("s4_mask_words", got.size(), 32'd0);
    mask = '0;

    // Continuous triggers with holdoff 10 give events 17 cycles apart.
    holdoff = 16'd10;
    apply_stimulus_run_reset(1'b0);
    trig[1] = 1'b1;
    step(40);
    trig = '0;
    step(10);
    check_output("s4_events", evt_cnt, 32'd3);
    check_output("s4_nwords", got.size(), 32'd9);
    check_output("s4_h0", got.size() > 0 ? got[0] : 32'hDEAD, 32'h80000000);
    check_output("s4_h1", got.size() > 3 ? got[3] : 32'hDEAD, 32'h80000011);
    check_output("s4_h2", got.size() > 6 ? got[6] : 32'hDEAD, 32'h80000022);
    holdoff = '0;

    // Stop during the window: that event still goes out, later hits do not.
    apply_stimulus_run_reset(1'b0);
    step(5);
    pulse(2);
    runstop = 1'b1;
    step(1);
    runstop = 1'b0;
    check_output("s5_stopped", 32'(running), 32'h0);
    step(10);
    pulse(2);
    step(10);
    check_output("s5_events", evt_cnt, 32'd1);
    check_output("s5_nwords", got.size(), 32'd3);
    check_output("s5_w0", got.size() > 0 ? got[0] : 32'hDEAD, 32'h80000005);
    check_output("s5_w1", got.size() > 1 ? got[1] : 32'hDEAD, 32'h00000004);

    // Run reset while the header word is being written aborts the event.
    apply_stimulus_run_reset(1'b0);
    step(3);
    pulse(9);
    step(3);
    apply_stimulus_run_reset(1'b0);
    check_output("s6_tvalid", 32'(tvalid), 32'h0);
    check_output("s6_events", evt_cnt, 32'd0);
    step(7);
    pulse(9);
    step(12);
    check_output("s6_w0", got.size() > 0 ? got[0] : 32'hDEAD, 32'h80000007);
    check_output("s6_w1", got.size() > 1 ? got[1] : 32'hDEAD, 32'h00000200);

    // Run reset together with stop: cleared and stopped.
    tready = 1'b0;
    pulse(4);
    step(10);
    check_output("s7_pre_tvalid", 32'(tvalid), 32'h1);
    apply_stimulus_run_reset(1'b1);
    check_output("s7_running", 32'(running), 32'h0);
    check_output("s7_events", evt_cnt, 32'd0);
    check_output("s7_tvalid", 32'(tvalid), 32'h0);
    pulse(4);
    step(10);
    check_output("s7_no_event", evt_cnt, 32'd0);
    check_output("s7_still_empty", 32'(tvalid), 32'h0);
    tready = 1'b1;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
